// File: rtl/tnoc_axi_region_decoder.sv
// Address-to-destination decoder for NoC requests: a programmable region table with
// lowest-index priority, a one-entry registered result stage and virtual-channel assignment.
module tnoc_axi_region_decoder #(
    parameter int ADDRESS_WIDTH = 64,
    parameter int ID_X_WIDTH    = 2,
    parameter int ID_Y_WIDTH    = 2,
    parameter int REGIONS       = 4,
    parameter int CHANNELS      = 2,
    parameter int VC_MODE       = 1,
    localparam int IW = (REGIONS > 1) ? $clog2(REGIONS) : 1,
    localparam int VW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cfg_write,
    input  logic [IW-1:0]            i_cfg_index,
    input  logic                     i_cfg_enable,
    input  logic [ADDRESS_WIDTH-1:0] i_cfg_base,
    input  logic [ADDRESS_WIDTH-1:0] i_cfg_mask,
    input  logic [ID_X_WIDTH-1:0]    i_cfg_id_x,
    input  logic [ID_Y_WIDTH-1:0]    i_cfg_id_y,
    input  logic [VW-1:0]            i_fixed_vc,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_req_address,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [ID_X_WIDTH-1:0]    o_rsp_id_x,
    output logic [ID_Y_WIDTH-1:0]    o_rsp_id_y,
    output logic [VW-1:0]            o_rsp_vc,
    output logic [IW-1:0]            o_rsp_region,
    output logic                     o_rsp_decode_error
);

    logic                     region_enable [REGIONS];
    logic [ADDRESS_WIDTH-1:0] region_base   [REGIONS];
    logic [ADDRESS_WIDTH-1:0] region_mask   [REGIONS];
    logic [ID_X_WIDTH-1:0]    region_id_x   [REGIONS];
    logic [ID_Y_WIDTH-1:0]    region_id_y   [REGIONS];

    logic                  hit;
    logic [IW-1:0]         hit_index;
    logic [ID_X_WIDTH-1:0] hit_id_x;
    logic [ID_Y_WIDTH-1:0] hit_id_y;
    logic [VW-1:0]         vc_count;
    logic [VW-1:0]         vc_select;
    logic                  accept;

    // Out-of-range indices match no loop iteration, so such writes are dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < REGIONS; r++) begin
                region_enable[r] <= 1'b0;
                region_base[r]   <= '0;
                region_mask[r]   <= '0;
                region_id_x[r]   <= '0;
                region_id_y[r]   <= '0;
            end
        end else if (i_cfg_write) begin
            for (int r = 0; r < REGIONS; r++) begin
                if (i_cfg_index == IW'(r)) begin
                    region_enable[r] <= i_cfg_enable;
                    region_base[r]   <= i_cfg_base;
                    region_mask[r]   <= i_cfg_mask;
                    region_id_x[r]   <= i_cfg_id_x;
                    region_id_y[r]   <= i_cfg_id_y;
                end
            end
        end
    end

    // Walk from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit       = 1'b0;
        hit_index = '0;
        hit_id_x  = '0;
        hit_id_y  = '0;
        for (int r = REGIONS - 1; r >= 0; r--) begin
            if (region_enable[r] &&
                ((i_req_address ^ region_base[r]) & region_mask[r]) == '0) begin
                hit       = 1'b1;
                hit_index = IW'(r);
                hit_id_x  = region_id_x[r];
                hit_id_y  = region_id_y[r];
            end
        end
    end

    assign o_req_ready = !o_rsp_valid || i_rsp_ready;
    assign accept      = i_req_valid && o_req_ready;
    assign vc_select   = (VC_MODE == 0) ? i_fixed_vc : vc_count;

    // Explicit wrap keeps the counter below CHANNELS for non-power-of-2 counts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vc_count <= '0;
        end else if (accept && hit) begin
            if (vc_count >= VW'(CHANNELS - 1)) begin
                vc_count <= '0;
            end else begin
                vc_count <= vc_count + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid        <= 1'b0;
            o_rsp_id_x         <= '0;
            o_rsp_id_y         <= '0;
            o_rsp_vc           <= '0;
            o_rsp_region       <= '0;
            o_rsp_decode_error <= 1'b0;
        end else if (accept) begin
            o_rsp_valid        <= 1'b1;
            o_rsp_id_x         <= hit_id_x;
            o_rsp_id_y         <= hit_id_y;
            o_rsp_vc           <= vc_select;
            o_rsp_region       <= hit_index;
            o_rsp_decode_error <= !hit;
        end else if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tnoc_axi_region_decoder.sv
// Directed bench for tnoc_axi_region_decoder: 3 regions, 3 round-robin VCs.
module tb_tnoc_axi_region_decoder;

    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_write;
    logic [1:0]    cfg_index;
    logic          cfg_enable;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_mask;
    logic [1:0]    cfg_id_x;
    logic [1:0]    cfg_id_y;
    logic [1:0]    fixed_vc;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_address;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id_x;
    logic [1:0]    rsp_id_y;
    logic [1:0]    rsp_vc;
    logic [1:0]    rsp_region;
    logic          rsp_decode_error;

    int tests  = 0;
    int failed = 0;

    tnoc_axi_region_decoder #(
        .ADDRESS_WIDTH(AW), .ID_X_WIDTH(2), .ID_Y_WIDTH(2),
        .REGIONS(3), .CHANNELS(3), .VC_MODE(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cfg_write(cfg_write), .i_cfg_index(cfg_index), .i_cfg_enable(cfg_enable),
        .i_cfg_base(cfg_base), .i_cfg_mask(cfg_mask),
        .i_cfg_id_x(cfg_id_x), .i_cfg_id_y(cfg_id_y), .i_fixed_vc(fixed_vc),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_address(req_address),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_id_x(rsp_id_x), .o_rsp_id_y(rsp_id_y), .o_rsp_vc(rsp_vc),
        .o_rsp_region(rsp_region), .o_rsp_decode_error(rsp_decode_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          err;
        logic [1:0]    region;
        logic [1:0]    x;
        logic [1:0]    y;
        logic [1:0]    vc;
    } vec_t;

    vec_t vecs[9];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Packed as {valid, error, region, x, y, vc}.
    task automatic chk_rsp(input string name, input logic v, input logic e, input logic [1:0] r,
                           input logic [1:0] x, input logic [1:0] y, input logic [1:0] vc);
        chk(name, 64'({rsp_valid, rsp_decode_error, rsp_region, rsp_id_x, rsp_id_y, rsp_vc}),
            64'({v, e, r, x, y, vc}));
    endtask

    task automatic cfg(input logic [1:0] idx, input logic en, input logic [AW-1:0] base,
                       input logic [AW-1:0] mask, input logic [1:0] x, input logic [1:0] y);
        cfg_index  = idx;
        cfg_enable = en;
        cfg_base   = base;
        cfg_mask   = mask;
        cfg_id_x   = x;
        cfg_id_y   = y;
        cfg_write  = 1'b1;
        cyc();
        cfg_write  = 1'b0;
    endtask

    initial begin
        //                  address                 err reg  x     y     vc
        vecs[0] = '{64'h4000_0000_0000_0010, 1'b0, 2'd1, 2'd0, 2'd1, 2'd0};
        vecs[1] = '{64'h0000_0000_0000_1234, 1'b0, 2'd0, 2'd1, 2'd0, 2'd1};
        vecs[2] = '{64'h8000_0000_0000_0000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd2};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 2'd1, 2'd0, 2'd1, 2'd2};
        vecs[4] = '{64'h3000_0000_0000_0000, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0};
        vecs[5] = '{64'hC000_0000_0000_0000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd1};
        vecs[6] = '{64'h4000_0000_0000_0000, 1'b0, 2'd1, 2'd0, 2'd1, 2'd1};
        vecs[7] = '{64'h0000_0000_0000_0000, 1'b0, 2'd0, 2'd1, 2'd0, 2'd2};
        vecs[8] = '{64'h5555_0000_0000_0000, 1'b0, 2'd1, 2'd0, 2'd1, 2'd0};

        rst_n = 1'b0; cfg_write = 1'b0; cfg_index = '0; cfg_enable = 1'b0;
        cfg_base = '0; cfg_mask = '0; cfg_id_x = '0; cfg_id_y = '0; fixed_vc = '0;
        req_valid = 1'b0; req_address = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_rsp("reset_outputs", 0, 0, 0, 0, 0, 0);
        chk("reset_ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;
        cyc();

        // Empty table: everything is a decode error.
        req_valid = 1'b1; req_address = 64'h0000_0000_0000_1000;
        cyc();
        chk_rsp("empty_table_error", 1, 1, 0, 0, 0, 0);
        req_valid = 1'b0;
        cyc();
        chk("valid_drops", 64'(rsp_valid), 64'd0);

        cfg(2'd0, 1'b1, 64'h0, 64'hC000_0000_0000_0000, 2'd1, 2'd0);
        cfg(2'd1, 1'b1, 64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000, 2'd0, 2'd1);
        cfg(2'd3, 1'b1, 64'h0, 64'h0, 2'd3, 2'd3);  // index beyond table: must not land anywhere

        for (int i = 0; i < 9; i++) begin
            req_valid   = 1'b1;
            req_address = vecs[i].addr;
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'd1);
            cyc();
            chk_rsp($sformatf("vec%0d", i), 1, vecs[i].err, vecs[i].region,
                    vecs[i].x, vecs[i].y, vecs[i].vc);
        end
        req_valid = 1'b0;
        cyc();
        chk("table_valid_drops", 64'(rsp_valid), 64'd0);

        // Backpressure: counter is 1 here.
        req_valid = 1'b1; req_address = 64'h0000_0000_0000_0001;
        cyc();
        chk_rsp("stall_first", 1, 0, 0, 1, 0, 1);
        rsp_ready = 1'b0; req_address = 64'h4000_0000_0000_0005;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("stall_ready_%0d", k), 64'(req_ready), 64'd0);
            chk_rsp($sformatf("stall_hold_%0d", k), 1, 0, 0, 1, 0, 1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("stall_release_ready", 64'(req_ready), 64'd1);
        cyc();
        chk_rsp("stall_no_bubble", 1, 0, 1, 0, 1, 2);
        req_valid = 1'b0;
        cyc();
        chk("stall_valid_drops", 64'(rsp_valid), 64'd0);

        // Overlapping catch-all regions: lowest index wins. Counter is 0.
        cfg(2'd0, 1'b1, 64'h0, 64'h0, 2'd1, 2'd0);
        cfg(2'd2, 1'b1, 64'h1234, 64'h0, 2'd2, 2'd3);
        req_valid = 1'b1; req_address = 64'hC000_0000_0000_0000;
        cyc();
        chk_rsp("overlap_a", 1, 0, 0, 1, 0, 0);
        req_address = 64'h4000_0000_0000_0000;
        cyc();
        chk_rsp("overlap_b", 1, 0, 0, 1, 0, 1);
        req_valid = 1'b0;
        cfg(2'd2, 1'b0, 64'h0, 64'h0, 2'd0, 2'd0);

        // Same-cycle disable of region 0 and a request that hits it.
        cfg_index = 2'd0; cfg_enable = 1'b0; cfg_base = '0; cfg_mask = '0;
        cfg_id_x = '0; cfg_id_y = '0; cfg_write = 1'b1;
        req_valid = 1'b1; req_address = 64'hC000_0000_0000_0000;
        cyc();
        cfg_write = 1'b0;
        chk_rsp("cfg_race_old_table", 1, 0, 0, 1, 0, 2);
        cyc();
        chk_rsp("cfg_race_new_table", 1, 1, 0, 0, 0, 0);

        // Reset while a result is held.
        req_address = 64'h4000_0000_0000_0000;
        cyc();
        chk_rsp("pre_reset_hit", 1, 0, 1, 0, 1, 0);
        rsp_ready = 1'b0; req_valid = 1'b0;
        cyc();
        chk_rsp("pre_reset_hold", 1, 0, 1, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_rsp("async_reset_clears", 0, 0, 0, 0, 0, 0);
        chk("async_reset_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        chk("post_reset_ready", 64'(req_ready), 64'd1);
        chk("post_reset_valid", 64'(rsp_valid), 64'd0);
        req_valid = 1'b1; rsp_ready = 1'b1;
        cyc();
        chk_rsp("post_reset_table_cleared", 1, 1, 0, 0, 0, 0);
        req_valid = 1'b0;
        cfg(2'd1, 1'b1, 64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000, 2'd0, 2'd1);
        req_valid = 1'b1;
        cyc();
        chk_rsp("post_reset_vc_zero", 1, 0, 1, 0, 1, 0);
        req_valid = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/tnoc_axi_region_decoder.md
TNOC_AXI_REGION_DECODER -- requirements
Module: tnoc_axi_region_decoder

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 64, request address width.
REQ-002 The block SHALL have parameter ID_X_WIDTH, default 2, destination X id width.
REQ-003 The block SHALL have parameter ID_Y_WIDTH, default 2, destination Y id width.
REQ-004 The block SHALL have parameter REGIONS, default 4, number of programmable address regions (1..16); IW = max(1, clog2(REGIONS)).
REQ-005 The block SHALL have parameter CHANNELS, default 2, number of virtual channels (1..8); VW = max(1, clog2(CHANNELS)).
REQ-006 The block SHALL have parameter VC_MODE, default 1, VC assignment mode: 0 = fixed from i_fixed_vc, 1 = round-robin.
REQ-007 The block SHALL have these ports, one clock, reset asynchronous active-low:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cfg_write  in  1  region table write strobe
- i_cfg_index  in  IW  region index written
- i_cfg_enable  in  1  region enable
- i_cfg_base  in  ADDRESS_WIDTH  region base
- i_cfg_mask  in  ADDRESS_WIDTH  compare mask (1 = compared bit)
- i_cfg_id_x  in  ID_X_WIDTH  region destination X
- i_cfg_id_y  in  ID_Y_WIDTH  region destination Y
- i_fixed_vc  in  VW  VC used when VC_MODE=0
- i_req_valid  in  1  decode request valid
- o_req_ready  out  1  decode request ready
- i_req_address  in  ADDRESS_WIDTH  address to decode
- o_rsp_valid  out  1  decode result valid
- i_rsp_ready  in  1  decode result accepted
- o_rsp_id_x  out  ID_X_WIDTH  destination X
- o_rsp_id_y  out  ID_Y_WIDTH  destination Y
- o_rsp_vc  out  VW  assigned virtual channel
- o_rsp_region  out  IW  matched region index
- o_rsp_decode_error  out  1  no enabled region matched

Function
REQ-008 Region table SHALL be registered; i_cfg_write with i_cfg_index < REGIONS updates that entry on the clock edge; index >= REGIONS SHALL be ignored.
REQ-009 Region r SHALL match when enabled and (i_req_address & mask_r) == (base_r & mask_r); mask all-zero on an enabled region matches every address.
REQ-010 Multiple matches SHALL resolve to the lowest region index.
REQ-011 No match SHALL give decode_error=1, id_x=0, id_y=0, region=0.
REQ-012 Request accepted when i_req_valid && o_req_ready; o_req_ready SHALL equal !o_rsp_valid || i_rsp_ready (one-entry output register, full throughput).
REQ-013 Latency SHALL be exactly one cycle: result registered on the accept edge, o_rsp_valid high the next cycle.
REQ-014 o_rsp_* SHALL hold stable while o_rsp_valid && !i_rsp_ready; o_rsp_valid drops after the handshake unless a new request is accepted the same cycle.
REQ-015 Config write and request accepted in the same cycle: decode SHALL use the table contents before the write.
REQ-016 VC_MODE=0: o_rsp_vc SHALL equal i_fixed_vc sampled at accept.
REQ-017 VC_MODE=1: o_rsp_vc SHALL equal a VW-bit counter sampled at accept; counter increments after each accepted request with decode_error=0, wrapping CHANNELS-1 -> 0; decode-error requests do not advance it.
REQ-018 Counter SHALL never reach a value >= CHANNELS, including non-power-of-2 CHANNELS.

Reset
REQ-019 i_rst_n low SHALL asynchronously clear: all entries disabled, base/mask/id 0, VC counter 0, o_rsp_valid 0, all o_rsp_* 0.
REQ-020 Reset mid-transaction SHALL discard the held result; o_req_ready SHALL be 1 from the first cycle after release.

Verification
REQ-021 After reset, request 0x0000_0000_0000_1000 -> o_rsp_valid next cycle, decode_error=1, id 0/0, vc=0.
REQ-022 Region 0 base 0x0, mask 0xC000_0000_0000_0000, id(1,0); region 1 base 0x4000_0000_0000_0000, same mask, id(0,1); address 0x4000_0000_0000_0010 -> region=1, id(0,1), error=0.
REQ-023 Regions 0 and 2 both enabled with mask 0 -> any address returns region=0.
REQ-024 VC_MODE=1, CHANNELS=3, five matching back-to-back requests with i_rsp_ready=1 -> vc 0,1,2,0,1, one result per cycle; interleaved decode-error request leaves sequence unchanged.
REQ-025 i_rsp_ready=0 for 4 cycles with pending result -> o_req_ready=0, o_rsp_* stable; ready=1 with new request same cycle -> next result follows without bubble.
REQ-026 Same-cycle cfg write disabling region 0 and request hitting it -> result region=0 error=0; next request to same address -> decode_error=1.
